// File: rtl/uart_tx.sv
// uart_tx - serial UART transmitter.
//
// Frames one byte per accepted request into start, 7/8 data bits (LSB first),
// optional odd/even parity and 1/2 stop bits. Each bit lasts CLKS_PER_BIT
// clocks. Data and configuration are latched when the request is accepted,
// so input changes mid-frame do not disturb the frame in flight.
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active low
//   tx_start  send request, only sampled while idle
//   tx_data   byte to send, bit 0 first
//   d_num     1 = 8 data bits, 0 = 7 data bits (bit 7 ignored)
//   s_num     1 = one stop bit, 0 = two stop bits
//   par       00/11 none, 01 odd, 10 even
//   tx        serial line (registered, idles high)
//   busy      high while a frame is on the line
//   done      one-cycle pulse on the first idle cycle after a frame
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       d_num,
    input  logic       s_num,
    input  logic [1:0] par,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cyc_cnt, cyc_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shreg, sh_d;
    logic          d_num_q, d_num_d;
    logic          s_num_q, s_num_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          tx_d, busy_d, done_d;

    logic          bit_end;
    logic [2:0]    bit_last;
    logic [7:0]    data_masked;
    logic          data_xor;

    assign bit_end     = (cyc_cnt == CYC_LAST);
    assign bit_last    = d_num_q ? 3'd7 : 3'd6;
    // In 7-bit mode bit 7 is neither sent nor counted in the parity.
    assign data_masked = d_num ? tx_data : {1'b0, tx_data[6:0]};
    assign data_xor    = ^data_masked;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            d_num_q   <= 1'b0;
            s_num_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cyc_cnt   <= cyc_d;
            bit_cnt   <= bit_d;
            shreg     <= sh_d;
            d_num_q   <= d_num_d;
            s_num_q   <= s_num_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx        <= tx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        cyc_d     = cyc_cnt;
        bit_d     = bit_cnt;
        sh_d      = shreg;
        d_num_d   = d_num_q;
        s_num_d   = s_num_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        // Cycle counter free-runs inside a frame and wraps on each bit boundary.
        if (state == IDLE) begin
            cyc_d = '0;
        end else begin
            cyc_d = bit_end ? '0 : cyc_cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_d   = START;
                    sh_d      = data_masked;
                    d_num_d   = d_num;
                    s_num_d   = s_num;
                    par_en_d  = (par == 2'b01) || (par == 2'b10);
                    par_bit_d = (par == 2'b01) ? ~data_xor : data_xor;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == bit_last) begin
                        state_d = par_en_q ? PARITY : STOP1;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                        sh_d  = {1'b0, shreg[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP1;
            end
            STOP1: begin
                if (bit_end) state_d = s_num_q ? IDLE : STOP2;
            end
            STOP2: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: derive them from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state != IDLE) && (state_d == IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks every bit period of each frame against
// a hand-computed bit vector, frame-end timing, back-to-back frames,
// mid-frame input disturbance and mid-frame reset.
module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
    logic       tx;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .d_num    (d_num),
        .s_num    (s_num),
        .par      (par),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected frame bits, index 0 sent first.
    function automatic void build(input logic [7:0] d, input logic dn, input logic sn,
                                  input logic [1:0] p, output logic [11:0] v, output int nb);
        logic x;
        v  = '0;
        nb = 1;
        for (int i = 0; i < (dn ? 8 : 7); i++) begin
            v[nb] = d[i];
            nb++;
        end
        x = dn ? ^d : ^d[6:0];
        if (p == 2'b01 || p == 2'b10) begin
            v[nb] = (p == 2'b01) ? ~x : x;
            nb++;
        end
        v[nb] = 1'b1;
        nb++;
        if (!sn) begin
            v[nb] = 1'b1;
            nb++;
        end
    endfunction

    // Request a frame in the current cycle (A) and check it through A+F+1.
    // Returns at A+F+1 without advancing, so a following call is back-to-back.
    task automatic frame(input string name, input logic [7:0] d, input logic dn,
                         input logic sn, input logic [1:0] p,
                         input logic [11:0] exp, input int nb,
                         input bit hold, input bit disturb);
        int hits, busy_bad, done_bad;
        tx_data  = d;
        d_num    = dn;
        s_num    = sn;
        par      = p;
        tx_start = 1'b1;
        cyc();
        if (!hold) tx_start = 1'b0;
        busy_bad = 0;
        done_bad = 0;
        for (int b = 0; b < nb; b++) begin
            hits = 0;
            for (int k = 0; k < CPB; k++) begin
                if (tx == exp[b]) hits++;
                if (!busy) busy_bad++;
                if (done) done_bad++;
                if (disturb) begin
                    tx_start = 1'($urandom);
                    tx_data  = 8'($urandom);
                    d_num    = 1'($urandom);
                    par      = 2'($urandom);
                end
                cyc();
            end
            chk($sformatf("%s bit%0d cycles", name, b), hits, CPB);
        end
        if (disturb) tx_start = 1'b0;
        chk({name, " busy during frame"}, busy_bad, 0);
        chk({name, " done during frame"}, done_bad, 0);
        chk({name, " end busy"}, int'(busy), 0);
        chk({name, " end done"}, int'(done), 1);
        chk({name, " end tx"}, int'(tx), 1);
    endtask

    initial begin
        logic [11:0] v;
        int nb, bad;

        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        d_num    = 1'b1;
        s_num    = 1'b1;
        par      = 2'b00;
        repeat (3) cyc();
        chk("reset tx", int'(tx), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst = 1'b1;
        cyc();

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        frame("8N1_A5", 8'hA5, 1'b1, 1'b1, 2'b00, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0);
        cyc();
        chk("8N1_A5 done pulse width", int'(done), 0);

        // 8E1 0xA5: four ones -> even parity bit 0
        frame("8E1_A5", 8'hA5, 1'b1, 1'b1, 2'b10, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
        cyc();
        // 8O1 0xA5: odd parity bit 1
        frame("8O1_A5", 8'hA5, 1'b1, 1'b1, 2'b01, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
        cyc();
        // 7O2 0xD5: data 0x55 (1,0,1,0,1,0,1), four ones -> parity 1, two stops
        frame("7O2_D5", 8'hD5, 1'b0, 1'b0, 2'b01, {2'b11, 1'b1, 7'h55, 1'b0}, 11, 1'b0, 1'b0);
        cyc();
        // par=11 is no parity: 8N2 0x3C
        frame("8N2_3C", 8'h3C, 1'b1, 1'b0, 2'b11, {1'b0, 2'b11, 8'h3C, 1'b0}, 11, 1'b0, 1'b0);
        cyc();

        // Back-to-back: start held through the first frame, accepted at A+F+1.
        frame("b2b_00", 8'h00, 1'b1, 1'b1, 2'b00, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 1'b1, 1'b0);
        frame("b2b_FF", 8'hFF, 1'b1, 1'b1, 2'b00, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0);
        cyc();
        chk("b2b done pulse width", int'(done), 0);

        // Inputs churn mid-frame: frame unchanged, no extra frame afterwards.
        frame("dist_3C", 8'h3C, 1'b1, 1'b1, 2'b00, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b1);
        bad = 0;
        repeat (2 * CPB) begin
            cyc();
            if (busy || !tx || done) bad++;
        end
        chk("dist no extra frame", bad, 0);

        // Reset during bit 4 together with a new request: reset wins.
        tx_data  = 8'h3C;
        d_num    = 1'b1;
        s_num    = 1'b1;
        par      = 2'b00;
        tx_start = 1'b1;
        cyc();
        tx_start = 1'b0;
        repeat (4 * CPB + CPB / 2) cyc();
        chk("rst pre busy", int'(busy), 1);
        rst      = 1'b0;
        tx_start = 1'b1;
        cyc();
        chk("rst tx", int'(tx), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        rst      = 1'b1;
        tx_start = 1'b0;
        bad = 0;
        repeat (2 * CPB) begin
            cyc();
            if (busy || !tx || done) bad++;
        end
        chk("rst no done, request dropped", bad, 0);

        // All 16 d_num/s_num/par combinations with random bytes.
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 2; r++) begin
                logic [7:0] d;
                d = 8'($urandom);
                build(d, c[0], c[1], c[3:2], v, nb);
                frame($sformatf("cfg%0d", c), d, c[0], c[1], c[3:2], v, nb, 1'b0, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
